mig_sweep_ctrl: RTL and testbench
=================================

MIG_SWEEP_CTRL -- requirements
Module: mig_sweep_ctrl

Interface
REQ-001 Parameter SETTLE_CYCLES, default 1, is the number of wait cycles after driving a minterm before y_i is sampled; the legal range SHALL be 0..15.
REQ-002 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  sweep request; sampled only in IDLE.
REQ-005 abort  input  1  terminates a sweep in progress.
REQ-006 x_o  output  4  minterm driven into the combinational function under test; x_o[0] drives x0 and x_o[3] drives x3.
REQ-007 y_i  input  1  function output y0 returned from the function under test.
REQ-008 tt_o  output  16  captured truth table; tt_o[m] is y_i sampled while x_o==m.
REQ-009 busy  output  1  high while a sweep is in progress.
REQ-010 done  output  1  one-cycle pulse when a sweep completes normally.
REQ-011 valid  output  1  high when tt_o holds a complete, unaborted sweep.

Function
REQ-012 The FSM SHALL have three states: IDLE, SWEEP and DONE.
REQ-013 In IDLE, when start=1 and abort=0, the FSM SHALL go to SWEEP next cycle, clear the minterm index m to 0 and the settle counter s to 0, and clear valid.
REQ-014 In IDLE, start together with abort SHALL be ignored, with abort taking priority.
REQ-015 In SWEEP, x_o SHALL equal m; s SHALL increment each cycle while s<SETTLE_CYCLES.
REQ-016 In the SWEEP cycle where s==SETTLE_CYCLES, tt_o[m] SHALL load y_i; s SHALL return to 0; m SHALL increment modulo 16.
REQ-017 Each minterm SHALL occupy exactly SETTLE_CYCLES+1 cycles, so the sweep lasts 16*(SETTLE_CYCLES+1) cycles.
REQ-018 The sample taken at m==15 SHALL move the FSM to DONE; m SHALL wrap to 0 and SHALL NOT start another pass.
REQ-019 DONE SHALL last exactly one cycle with done=1 and valid=1, then return to IDLE; valid SHALL stay 1 until the next accepted start, abort or reset.
REQ-020 busy SHALL be 1 exactly in SWEEP.
REQ-021 x_o SHALL be 0 in IDLE and DONE.
REQ-022 start asserted in SWEEP or DONE SHALL be ignored; it SHALL NOT be queued.
REQ-023 abort in SWEEP SHALL return the FSM to IDLE next cycle with valid=0 and done=0.
REQ-024 On abort, tt_o bits already captured SHALL be retained and the uncaptured bits SHALL be left unchanged.
REQ-025 abort in IDLE or DONE SHALL clear valid and have no other effect, except that the done pulse in progress still completes.
REQ-026 tt_o bits SHALL change only on a sample cycle or on reset.

Reset
REQ-027 While rst_n=0, the block SHALL immediately, independent of clk, force state=IDLE, m=0, s=0, tt_o=16'h0000, x_o=0, busy=0, done=0, valid=0.
REQ-028 Reset asserted mid-sweep SHALL discard the sweep; the first start accepted after rst_n deasserts SHALL begin at m=0.

Configuration
REQ-029 The macro TT_COMPARE_EN SHALL control the compare feature.
REQ-030 With TT_COMPARE_EN defined, the block SHALL add input exp_tt[15:0] and outputs match (1 bit) and mis_idx (4 bits).
REQ-031 With TT_COMPARE_EN defined, match SHALL be registered as valid && (tt_o==exp_tt).
REQ-032 With TT_COMPARE_EN defined, mis_idx SHALL be the lowest m with tt_o[m]!=exp_tt[m] when valid=1 and match=0, and 0 otherwise; both outputs SHALL reset to 0.
REQ-033 Without TT_COMPARE_EN, these ports and their logic SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-034 SETTLE_CYCLES=0, y_i=x_o[0]&x_o[1], one-cycle start -> busy high for 16 cycles, done pulse in the next cycle, tt_o=16'h8888, valid=1.
REQ-035 SETTLE_CYCLES=3, y_i=x_o[3] -> each x_o value held 4 cycles, done in the cycle after 64 SWEEP cycles, tt_o=16'hFF00.
REQ-036 SETTLE_CYCLES=0, abort on the 6th SWEEP cycle after a prior valid sweep of 16'hFFFF with y_i=0 -> IDLE next cycle, valid=0, no done, tt_o=16'hFFE0.
REQ-037 start held high continuously -> second sweep begins only after the return to IDLE; start pulses during SWEEP produce no extra sweep.
REQ-038 rst_n pulsed low mid-sweep, asynchronous to clk -> all outputs 0 immediately; a new start yields a correct full truth table.
REQ-039 TT_COMPARE_EN defined, y_i=x_o[0]&x_o[1]: exp_tt=16'h8888 gives match=1 and mis_idx=0; exp_tt=16'h8898 gives match=0 and mis_idx=4.

Source files
------------

// File: rtl/mig_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mig_sweep_ctrl
// Description : Walks a 4-input function through all 16 minterms and captures
//               its output as a 16-bit truth table. Optional compare against
//               an expected table when TT_COMPARE_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module mig_sweep_ctrl #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    output logic [3:0]  x_o,
    input  logic        y_i,
    output logic [15:0] tt_o,
    output logic        busy,
    output logic        done,
    output logic        valid
`ifdef TT_COMPARE_EN
    ,
    input  logic [15:0] exp_tt,
    output logic        match,
    output logic [3:0]  mis_idx
`endif
);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_sweep = 2'd1;
    localparam logic [1:0] c_st_done  = 2'd2;
    localparam logic [3:0] c_settle   = 4'(SETTLE_CYCLES);

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [3:0]  r_m;
    logic [3:0]  r_s;
    logic [15:0] r_tt;
    logic        r_valid;
    logic        w_accept;
    logic        w_sample;
    logic        w_last;

    // abort outranks both a start in IDLE and a sample in SWEEP
    assign w_accept = (r_state == c_st_idle) && start && !abort;
    assign w_sample = (r_state == c_st_sweep) && !abort && (r_s == c_settle);
    assign w_last   = w_sample && (r_m == 4'hF);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle:  if (w_accept) w_state_nxt = c_st_sweep;
            c_st_sweep: begin
                if (abort)       w_state_nxt = c_st_idle;
                else if (w_last) w_state_nxt = c_st_done;
            end
            c_st_done:  w_state_nxt = c_st_idle;
            default:    w_state_nxt = c_st_idle;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        x_o  = 4'h0;
        case (r_state)
            c_st_sweep: begin
                busy = 1'b1;
                x_o  = r_m;
            end
            c_st_done:  done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m <= 4'h0;
            r_s <= 4'h0;
        end else if (w_accept) begin
            r_m <= 4'h0;
            r_s <= 4'h0;
        end else if ((r_state == c_st_sweep) && !abort) begin
            if (r_s == c_settle) begin
                r_s <= 4'h0;
                r_m <= r_m + 4'd1;
            end else begin
                r_s <= r_s + 4'd1;
            end
        end
    end

    // Unsampled bits keep their old contents, including across an abort.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tt <= 16'h0000;
        end else if (w_sample) begin
            r_tt[r_m] <= y_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
        end else if (abort || w_accept) begin
            r_valid <= 1'b0;
        end else if (w_last) begin
            r_valid <= 1'b1;
        end
    end

    assign tt_o  = r_tt;
    assign valid = r_valid;

`ifdef TT_COMPARE_EN
    logic [15:0] w_diff;
    logic [3:0]  w_first;
    logic        r_match;
    logic [3:0]  r_mis_idx;

    assign w_diff = r_tt ^ exp_tt;

    always_comb begin
        w_first = 4'h0;
        for (int i = 15; i >= 0; i--) begin
            if (w_diff[i]) w_first = 4'(i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_match   <= 1'b0;
            r_mis_idx <= 4'h0;
        end else begin
            r_match   <= r_valid && (w_diff == 16'h0000);
            r_mis_idx <= (r_valid && (w_diff != 16'h0000)) ? w_first : 4'h0;
        end
    end

    assign match   = r_match;
    assign mis_idx = r_mis_idx;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mig_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mig_sweep_ctrl
// Description : Randomized self-checking bench for mig_sweep_ctrl against a
//               sweep-position reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mig_sweep_ctrl;

    localparam int ST        = 2;
    localparam int SWEEP_LEN = 16 * (ST + 1);

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        y_i;
    logic [3:0]  x_o;
    logic [15:0] tt_o;
    logic        busy;
    logic        done;
    logic        valid;
    logic [15:0] func_tt = 16'h0000;
`ifdef TT_COMPARE_EN
    logic [15:0] exp_tt = 16'h0000;
    logic        match;
    logic [3:0]  mis_idx;
`endif

    int total = 0;
    int bad   = 0;

    // reference model: phase 0=idle 1=sweeping 2=done, k=cycles into sweep
    int          mdl_phase;
    int          mdl_k;
    logic [15:0] mdl_tt;
    logic        mdl_valid;
    logic        mdl_match;
    logic [3:0]  mdl_mis;

    mig_sweep_ctrl #(.SETTLE_CYCLES(ST)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .abort  (abort),
        .x_o    (x_o),
        .y_i    (y_i),
        .tt_o   (tt_o),
        .busy   (busy),
        .done   (done),
        .valid  (valid)
`ifdef TT_COMPARE_EN
        ,
        .exp_tt (exp_tt),
        .match  (match),
        .mis_idx(mis_idx)
`endif
    );

    always #5 clk = ~clk;

    assign y_i = func_tt[x_o];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        if (obs !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
        end
    endtask

    task automatic model_reset();
        mdl_phase = 0;
        mdl_k     = 0;
        mdl_tt    = 16'h0000;
        mdl_valid = 1'b0;
        mdl_match = 1'b0;
        mdl_mis   = 4'h0;
    endtask

    task automatic check_outputs();
        check_val("busy", busy, mdl_phase == 1);
        check_val("done", done, mdl_phase == 2);
        check_val("valid", valid, mdl_valid);
        check_val("x_o", x_o, (mdl_phase == 1) ? mdl_k / (ST + 1) : 0);
        check_val("tt_o", tt_o, mdl_tt);
`ifdef TT_COMPARE_EN
        check_val("match", match, mdl_match);
        check_val("mis_idx", mis_idx, mdl_mis);
`endif
    endtask

    task automatic model_step();
        int idx;
`ifdef TT_COMPARE_EN
        mdl_match = mdl_valid && (mdl_tt == exp_tt);
        mdl_mis   = 4'h0;
        if (mdl_valid && (mdl_tt != exp_tt)) begin
            for (int i = 15; i >= 0; i--)
                if (mdl_tt[i] != exp_tt[i]) mdl_mis = 4'(i);
        end
`endif
        case (mdl_phase)
            0: begin
                if (abort) mdl_valid = 1'b0;
                else if (start) begin
                    mdl_phase = 1;
                    mdl_k     = 0;
                    mdl_valid = 1'b0;
                end
            end
            1: begin
                if (abort) begin
                    mdl_phase = 0;
                    mdl_valid = 1'b0;
                end else begin
                    idx = mdl_k / (ST + 1);
                    if (mdl_k % (ST + 1) == ST) mdl_tt[idx] = func_tt[idx];
                    mdl_k++;
                    if (mdl_k == SWEEP_LEN) begin
                        mdl_phase = 2;
                        mdl_valid = 1'b1;
                    end
                end
            end
            default: begin
                mdl_phase = 0;
                if (abort) mdl_valid = 1'b0;
            end
        endcase
    endtask

    task automatic cycle(input logic st, input logic ab);
        start = st;
        abort = ab;
        @(negedge clk);
        check_outputs();
        model_step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        model_reset();
        #12;
        check_outputs();
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // AND of x0,x1 gives 16'h8888
        func_tt = 16'h8888;
`ifdef TT_COMPARE_EN
        exp_tt = 16'h8888;
`endif
        cycle(1'b1, 1'b0);
        repeat (SWEEP_LEN + 3) cycle(1'b0, 1'b0);
        check_val("and_tt", tt_o, 16'h8888);
        check_val("and_valid", valid, 1'b1);
`ifdef TT_COMPARE_EN
        check_val("and_match", match, 1'b1);
        exp_tt = 16'h8898;
        repeat (2) cycle(1'b0, 1'b0);
        check_val("mis_idx4", mis_idx, 4'd4);
`endif

        // full sweep of ones, then a zero sweep aborted at minterm 5
        func_tt = 16'hFFFF;
        cycle(1'b1, 1'b0);
        repeat (SWEEP_LEN + 2) cycle(1'b0, 1'b0);
        func_tt = 16'h0000;
        cycle(1'b1, 1'b0);
        repeat (5 * (ST + 1)) cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b0);
        check_val("abort_tt", tt_o, 16'hFFE0);
        check_val("abort_valid", valid, 1'b0);
        check_val("abort_busy", busy, 1'b0);

        // start held high: sweeps back to back only via IDLE
        func_tt = 16'hA5C3;
        repeat (2 * SWEEP_LEN + 10) cycle(1'b1, 1'b0);

        repeat (1500) begin
            if (mdl_phase == 0 && ($urandom % 4) == 0) func_tt = 16'($urandom);
`ifdef TT_COMPARE_EN
            exp_tt = (($urandom % 2) == 0) ? func_tt : (func_tt ^ (16'h0001 << ($urandom % 16)));
`endif
            cycle(($urandom % 5) == 0, ($urandom % 60) == 0);
        end

        // asynchronous reset in the middle of a sweep
        repeat (4) cycle(1'b0, 1'b0);
        cycle(1'b1, 1'b0);
        repeat (10) cycle(1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        func_tt = 16'h3C96;
        cycle(1'b1, 1'b0);
        repeat (SWEEP_LEN + 2) cycle(1'b0, 1'b0);
        check_val("post_rst_tt", tt_o, 16'h3C96);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
